// File: rtl/mmio_devices_pkg.sv
// Shared definitions for the memory-mapped device block: address map, CTRL bit
// positions and the per-device status record with its update rule.
package mmio_devices_pkg;

    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_LEDG  = 32'hF000_0008;
    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_SDATA = 32'hF000_0014;
    localparam logic [31:0] A_TCNT  = 32'hF000_0020;
    localparam logic [31:0] A_TLIM  = 32'hF000_0024;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_TCTRL = 32'hF000_0120;

    localparam int RDY = 0;
    localparam int OVR = 2;
    localparam int IE  = 8;

    typedef struct packed {
        logic ready;
        logic overrun;
        logic ie;
    } dev_status_t;

    function automatic logic [8:0] ctrl_bits(dev_status_t s);
        logic [8:0] r;
        r      = '0;
        r[RDY] = s.ready;
        r[OVR] = s.overrun;
        r[IE]  = s.ie;
        return r;
    endfunction

    // An event always leaves ready set; it only counts as an overrun when the
    // previous ready is not being consumed in the same cycle.
    function automatic dev_status_t status_next(dev_status_t cur, logic evt, logic rd_clr,
                                                logic ctrl_we, logic [8:0] wbits);
        dev_status_t nxt;
        logic        clr_rdy;
        logic        clr_ovr;
        clr_rdy     = rd_clr | (ctrl_we & ~wbits[RDY]);
        clr_ovr     = ctrl_we & ~wbits[OVR];
        nxt.ie      = ctrl_we ? wbits[IE] : cur.ie;
        nxt.ready   = evt | (cur.ready & ~clr_rdy);
        nxt.overrun = (cur.overrun & ~clr_ovr) | (evt & cur.ready & ~clr_rdy);
        return nxt;
    endfunction

endpackage

// File: rtl/mmio_devices_debounce.sv
// Switch debouncer: dout follows din once din has differed from dout and held
// one value for WINDOW consecutive cycles; fire pulses on the updating cycle.
module mmio_debounce #(
    parameter int WIDTH  = 10,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             fire
);

    localparam int CW = $clog2(WINDOW + 1);

    logic [WIDTH-1:0] last;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    run;

    // run is the length of the stable streak including the current sample.
    assign run  = (din == last) ? cnt + CW'(1) : CW'(1);
    assign fire = (din != dout) && (run == CW'(WINDOW));

    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            last <= din;
            if (fire) begin
                dout <= din;
                cnt  <= '0;
            end else if (din == dout) begin
                cnt <= '0;
            end else begin
                cnt <= run;
            end
        end
    end

endmodule

// File: rtl/mmio_devices.sv
// Memory-mapped LEDs, seven-seg, pushbuttons, debounced switches and an
// optional interval timer (present only when MMIO_TIMER_EN is defined).
module mmio_devices
    import mmio_devices_pkg::*;
#(
    parameter int DBITS           = 32,
    parameter int KEY_BITS        = 4,
    parameter int SW_BITS         = 10,
    parameter int LEDR_BITS       = 10,
    parameter int LEDG_BITS       = 8,
    parameter int HEX_BITS        = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_CYCLES     = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBITS-1:0]     addr,
    input  logic                 we,
    input  logic                 re,
    input  logic [DBITS-1:0]     wdata,
    output logic [DBITS-1:0]     rdata,
    output logic                 hit,
    input  logic [KEY_BITS-1:0]  key,
    input  logic [SW_BITS-1:0]   sw,
    output logic [LEDR_BITS-1:0] ledr,
    output logic [LEDG_BITS-1:0] ledg,
    output logic [HEX_BITS-1:0]  hex,
    output logic                 irq
);

    localparam logic [DBITS-1:0] AD_HEX   = DBITS'(A_HEX);
    localparam logic [DBITS-1:0] AD_LEDR  = DBITS'(A_LEDR);
    localparam logic [DBITS-1:0] AD_LEDG  = DBITS'(A_LEDG);
    localparam logic [DBITS-1:0] AD_KDATA = DBITS'(A_KDATA);
    localparam logic [DBITS-1:0] AD_SDATA = DBITS'(A_SDATA);
    localparam logic [DBITS-1:0] AD_TCNT  = DBITS'(A_TCNT);
    localparam logic [DBITS-1:0] AD_TLIM  = DBITS'(A_TLIM);
    localparam logic [DBITS-1:0] AD_KCTRL = DBITS'(A_KCTRL);
    localparam logic [DBITS-1:0] AD_SCTRL = DBITS'(A_SCTRL);
    localparam logic [DBITS-1:0] AD_TCTRL = DBITS'(A_TCTRL);

    logic [KEY_BITS-1:0] kdata;
    logic [KEY_BITS-1:0] key_n;
    logic [SW_BITS-1:0]  sdata;
    logic                k_evt;
    logic                s_evt;
    logic                t_irq;
    dev_status_t         kstat;
    dev_status_t         sstat;

    assign key_n = ~key;
    assign k_evt = (key_n != kdata);

    mmio_debounce #(
        .WIDTH  (SW_BITS),
        .WINDOW (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (sw),
        .dout  (sdata),
        .fire  (s_evt)
    );

`ifdef MMIO_TIMER_EN
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PW-1:0]    presc;
    logic [DBITS-1:0] tcnt;
    logic [DBITS-1:0] tlim;
    dev_status_t      tstat;
    logic             tick;
    logic             t_load;
    logic             t_evt;

    // A TCNT/TLIM write suppresses the tick of the same cycle entirely.
    assign tick   = (presc == PW'(TICK_CYCLES - 1));
    assign t_load = we && ((addr == AD_TCNT) || (addr == AD_TLIM));
    assign t_evt  = tick && !t_load && (tlim != '0) && (tcnt == tlim - DBITS'(1));
    assign t_irq  = tstat.ready & tstat.ie;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            tcnt  <= '0;
            tlim  <= '0;
            tstat <= '0;
        end else begin
            if (t_load || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            if (we && (addr == AD_TCNT)) begin
                tcnt <= wdata;
            end else if (t_evt) begin
                tcnt <= '0;
            end else if (tick && !t_load) begin
                tcnt <= tcnt + DBITS'(1);
            end
            if (we && (addr == AD_TLIM)) begin
                tlim <= wdata;
            end
            tstat <= status_next(tstat, t_evt, 1'b0, we && (addr == AD_TCTRL), wdata[8:0]);
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata};
    assign t_irq        = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (addr)
            AD_HEX:   rdata = DBITS'(hex);
            AD_LEDR:  rdata = DBITS'(ledr);
            AD_LEDG:  rdata = DBITS'(ledg);
            AD_KDATA: rdata = DBITS'(kdata);
            AD_SDATA: rdata = DBITS'(sdata);
            AD_KCTRL: rdata = DBITS'(ctrl_bits(kstat));
            AD_SCTRL: rdata = DBITS'(ctrl_bits(sstat));
`ifdef MMIO_TIMER_EN
            AD_TCNT:  rdata = tcnt;
            AD_TLIM:  rdata = tlim;
            AD_TCTRL: rdata = DBITS'(ctrl_bits(tstat));
`endif
            default:  hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hex   <= '0;
            ledr  <= '0;
            ledg  <= '0;
            kdata <= '0;
            kstat <= '0;
            sstat <= '0;
            irq   <= 1'b0;
        end else begin
            if (we && (addr == AD_HEX)) begin
                hex <= wdata[HEX_BITS-1:0];
            end
            if (we && (addr == AD_LEDR)) begin
                ledr <= wdata[LEDR_BITS-1:0];
            end
            if (we && (addr == AD_LEDG)) begin
                ledg <= wdata[LEDG_BITS-1:0];
            end
            if (k_evt) begin
                kdata <= key_n;
            end
            kstat <= status_next(kstat, k_evt, re && (addr == AD_KDATA),
                                 we && (addr == AD_KCTRL), wdata[8:0]);
            sstat <= status_next(sstat, s_evt, re && (addr == AD_SDATA),
                                 we && (addr == AD_SCTRL), wdata[8:0]);
            irq   <= (kstat.ready & kstat.ie) | (sstat.ready & sstat.ie) | t_irq;
        end
    end

endmodule

// File: tb/tb_mmio_devices.sv
// Self-checking bench for mmio_devices: register table, key/switch/timer
// sequences and randomized key/switch traffic against a behavioural model.
module tb_mmio_devices;

    localparam logic [31:0] A_HEX   = 32'hF000_0000;
    localparam logic [31:0] A_LEDR  = 32'hF000_0004;
    localparam logic [31:0] A_LEDG  = 32'hF000_0008;
    localparam logic [31:0] A_KDATA = 32'hF000_0010;
    localparam logic [31:0] A_SDATA = 32'hF000_0014;
    localparam logic [31:0] A_TCNT  = 32'hF000_0020;
    localparam logic [31:0] A_TLIM  = 32'hF000_0024;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_TCTRL = 32'hF000_0120;
    localparam int TICK = 2;
    localparam int WIN  = 16;
`ifdef MMIO_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = A_HEX;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  key = 4'hF;
    logic [9:0]  sw = '0;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [15:0] hex;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    mmio_devices #(
        .DBITS(32), .KEY_BITS(4), .SW_BITS(10), .LEDR_BITS(10), .LEDG_BITS(8),
        .HEX_BITS(16), .DEBOUNCE_CYCLES(WIN), .TICK_CYCLES(TICK)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
        .rdata(rdata), .hit(hit), .key(key), .sw(sw), .ledr(ledr), .ledg(ledg),
        .hex(hex), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr = a;
        #1;
        d = rdata;
        h = hit;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        bus_read(a, d, h);
        check(name, d, exp);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [15:0] exp_hex;
        logic [9:0]  exp_ledr;
        logic [7:0]  exp_ledg;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] reg_addrs[10];
    logic [31:0] exp_q[$];
    logic [9:0]  hist[$];
    logic [9:0]  sw_pool[4];

    initial begin
        logic [31:0] d;
        logic        h;
        logic [3:0]  kv, m_k;
        logic        m_rdy, m_ovr, m_irq, evt, do_re, allsame;
        logic [9:0]  m_s;
        logic        m_srdy, m_sovr;

        vecs[0] = '{A_HEX,         32'h0000_BEEF, 32'h0000_BEEF, 1'b1, 16'hBEEF, 10'h000, 8'h00};
        vecs[1] = '{A_LEDR,        32'h0000_02AA, 32'h0000_02AA, 1'b1, 16'hBEEF, 10'h2AA, 8'h00};
        vecs[2] = '{A_LEDG,        32'h0000_0081, 32'h0000_0081, 1'b1, 16'hBEEF, 10'h2AA, 8'h81};
        vecs[3] = '{32'hF000_0030, 32'h0000_DEAD, 32'h0000_0000, 1'b0, 16'hBEEF, 10'h2AA, 8'h81};
        vecs[4] = '{A_LEDR,        32'hFFFF_FFFF, 32'h0000_03FF, 1'b1, 16'hBEEF, 10'h3FF, 8'h81};
        vecs[5] = '{A_HEX,         32'h1234_5678, 32'h0000_5678, 1'b1, 16'h5678, 10'h3FF, 8'h81};
        vecs[6] = '{A_KDATA,       32'h0000_000F, 32'h0000_0000, 1'b1, 16'h5678, 10'h3FF, 8'h81};
        vecs[7] = '{32'hF000_0001, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 16'h5678, 10'h3FF, 8'h81};
        vecs[8] = '{A_LEDG,        32'h0000_0100, 32'h0000_0000, 1'b1, 16'h5678, 10'h3FF, 8'h00};
        reg_addrs = '{A_HEX, A_LEDR, A_LEDG, A_KDATA, A_SDATA, A_KCTRL, A_SCTRL,
                      A_TCNT, A_TLIM, A_TCTRL};
        sw_pool = '{10'h155, 10'h2AA, 10'h3FF, 10'h000};

        // ---------------- reset state ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus_read(reg_addrs[i], d, h);
            check($sformatf("reset_rd[%0d]", i), d, 32'h0);
            check($sformatf("reset_hit[%0d]", i), {31'b0, h}, {31'b0, (i >= 7) ? TIMER_ON : 1'b1});
        end
        check("reset_irq", {31'b0, irq}, 32'h0);

        // ---------------- register table ----------------
        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].a, vecs[i].d);
            bus_read(vecs[i].a, d, h);
            check($sformatf("tbl_rd[%0d]", i), d, vecs[i].exp_rd);
            check($sformatf("tbl_hit[%0d]", i), {31'b0, h}, {31'b0, vecs[i].exp_hit});
            check($sformatf("tbl_hex[%0d]", i), {16'b0, hex}, {16'b0, vecs[i].exp_hex});
            check($sformatf("tbl_ledr[%0d]", i), {22'b0, ledr}, {22'b0, vecs[i].exp_ledr});
            check($sformatf("tbl_ledg[%0d]", i), {24'b0, ledg}, {24'b0, vecs[i].exp_ledg});
        end
        do_reset();
        check("rst_hex", {16'b0, hex}, 32'h0);
        check("rst_ledr", {22'b0, ledr}, 32'h0);

        // ---------------- key: first press, ie and irq ----------------
        key = 4'b1110;
        step();
        check_reg("key_kdata", A_KDATA, 32'h1);
        check_reg("key_kctrl", A_KCTRL, 32'h001);
        check("key_irq_noie", {31'b0, irq}, 32'h0);
        step();
        check("key_irq_noie2", {31'b0, irq}, 32'h0);
        bus_write(A_KCTRL, 32'h101);
        check_reg("key_kctrl_w1", A_KCTRL, 32'h101);
        check("key_irq_lat", {31'b0, irq}, 32'h0);
        step();
        check("key_irq", {31'b0, irq}, 32'h1);
        bus_write(A_KCTRL, 32'h100);
        step();
        key = 4'hF;
        step();
        check_reg("key_rel_kdata", A_KDATA, 32'h0);
        check("key_irq_ie_lat", {31'b0, irq}, 32'h0);
        step();
        check("key_irq_ie", {31'b0, irq}, 32'h1);

        // ---------------- key: overrun, ctrl write, read vs event ----------------
        bus_write(A_KCTRL, 32'h000);
        key = 4'b1101;
        step();
        key = 4'b1111;
        step();
        check_reg("ovr_kctrl", A_KCTRL, 32'h005);
        bus_write(A_KCTRL, 32'h100);
        check_reg("ovr_clear", A_KCTRL, 32'h100);
        key = 4'b0111;
        step();
        check_reg("ev_kctrl", A_KCTRL, 32'h101);
        addr = A_KDATA;
        re   = 1'b1;
        key  = 4'b1111;
        step();
        re   = 1'b0;
        check_reg("rdev_kctrl", A_KCTRL, 32'h101);
        check_reg("rdev_kdata", A_KDATA, 32'h0);
        addr = A_KDATA;
        re   = 1'b1;
        step();
        re   = 1'b0;
        check_reg("rd_clear", A_KCTRL, 32'h100);

        // ---------------- key: randomized traffic vs model ----------------
        bus_write(A_KCTRL, 32'h000);
        step();
        bus_write(A_KCTRL, 32'h100);
        m_k = 4'h0; m_rdy = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
        for (int i = 0; i < 150; i++) begin
            kv    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : key;
            do_re = ($urandom_range(0, 2) == 0);
            key   = kv;
            check_reg("rnd_kctrl", A_KCTRL, {23'b0, 1'b1, 5'b0, m_ovr, 1'b0, m_rdy});
            check_reg("rnd_kdata", A_KDATA, {28'b0, m_k});
            check("rnd_irq", {31'b0, irq}, {31'b0, m_irq});
            re    = do_re;
            evt   = ((~kv) != m_k);
            m_irq = m_rdy;
            m_ovr = m_ovr | (evt & m_rdy & ~do_re);
            m_rdy = evt | (m_rdy & ~do_re);
            if (evt) m_k = ~kv;
            step();
            re = 1'b0;
        end
        key = 4'hF;
        step();

        // ---------------- reset discards a partial debounce count ----------------
        do_reset();
        sw = 10'h0AA;
        for (int i = 0; i < 10; i++) step();
        do_reset();
        for (int n = 1; n <= WIN; n++) begin
            step();
            check_reg("dbrst_sdata", A_SDATA, (n >= WIN) ? 32'h0AA : 32'h0);
        end

        // ---------------- switch toggle then hold ----------------
        sw = 10'h000;
        do_reset();
        for (int c = 0; c < 50; c++) exp_q.push_back(32'h0);
        for (int n = 1; n <= WIN; n++) exp_q.push_back((n >= WIN) ? 32'h155 : 32'h0);
        for (int c = 0; c < 50 + WIN; c++) begin
            sw = (c >= 50) ? 10'h155 : ((((c / 5) % 2) == 0) ? 10'h3FF : 10'h000);
            step();
            check_reg("hold_sdata", A_SDATA, exp_q.pop_front());
        end
        check_reg("hold_sctrl", A_SCTRL, 32'h001);

        // ---------------- switches: randomized traffic vs model ----------------
        bus_write(A_SCTRL, 32'h000);
        m_s = 10'h155; m_srdy = 1'b0; m_sovr = 1'b0;
        hist.delete();
        for (int i = 0; i < 400; i++) begin
            check_reg("rnd_sdata", A_SDATA, {22'b0, m_s});
            check_reg("rnd_sctrl", A_SCTRL, {29'b0, m_sovr, 1'b0, m_srdy});
            if ($urandom_range(0, 19) == 0) sw = sw_pool[$urandom_range(0, 3)];
            hist.push_back(sw);
            if (hist.size() > WIN) void'(hist.pop_front());
            allsame = (hist.size() == WIN);
            foreach (hist[j]) if (hist[j] != hist[0]) allsame = 1'b0;
            evt = allsame && (hist[0] != m_s);
            if (evt) m_s = hist[0];
            m_sovr = m_sovr | (evt & m_srdy);
            m_srdy = m_srdy | evt;
            step();
        end

        // ---------------- timer ----------------
`ifdef MMIO_TIMER_EN
        do_reset();
        bus_write(A_TCNT, 32'd5);
        step();
        do_reset();
        step();
        check_reg("presc_rst0", A_TCNT, 32'd0);
        step();
        check_reg("presc_rst1", A_TCNT, 32'd1);
        bus_write(A_TCNT, 32'd0);
        bus_write(A_TLIM, 32'd3);
        for (int n = 1; n <= 8; n++) begin
            step();
            check_reg("tlim3_tcnt", A_TCNT, 32'((n / TICK) % 3));
            check_reg("tlim3_rdy", A_TCTRL, ((n / TICK) >= 3) ? 32'h1 : 32'h0);
        end
        bus_write(A_TCTRL, 32'h000);
        bus_write(A_TLIM, 32'd0);
        bus_write(A_TCNT, 32'hFFFF_FFFE);
        for (int n = 1; n <= 8; n++) begin
            step();
            check_reg("free_tcnt", A_TCNT, 32'hFFFF_FFFE + 32'(n / TICK));
            check_reg("free_rdy", A_TCTRL, 32'h0);
        end
`else
        bus_write(A_TCNT, 32'd7);
        bus_write(A_TLIM, 32'd3);
        for (int i = 7; i < 10; i++) begin
            bus_read(reg_addrs[i], d, h);
            check($sformatf("notimer_rd[%0d]", i), d, 32'h0);
            check($sformatf("notimer_hit[%0d]", i), {31'b0, h}, 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
